nonrestoring_divider_param: RTL and testbench

- Parametrised successor of the team's 8-bit non-restoring divider. Generic WIDTH, per-operation signed/unsigned mode, valid/ready handshakes on input and output, divide-by-zero and signed-overflow flags.
- Computes one radix-2 quotient bit per cycle. Sits as a shared multi-cycle arithmetic unit behind the datapath issue logic.

---
 rtl/div_pkg.sv | 29 ++
 rtl/nr_div_step.sv | 24 ++
 rtl/nonrestoring_divider_param.sv | 170 +++++++++++++++++
 tb/tb_nonrestoring_divider_param.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the parametrised non-restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StDivide,
    StCorrect,
    StDone
  } div_state_e;

  localparam int unsigned DivWidth = 16;

  typedef struct packed {
    logic [DivWidth-1:0] quotient;
    logic [DivWidth-1:0] remainder;
    logic                div_by_zero;
    logic                overflow;
  } div_result_t;

  // Most negative two's-complement value of width w, zero-extended to 32 bits.
  function automatic logic [31:0] div_min(input int unsigned w);
    return 32'(1) << (w - 1);
  endfunction

  function automatic logic [31:0] div_ones(input int unsigned w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'(1) << w) - 32'(1));
  endfunction

endpackage

// File: rtl/nr_div_step.sv
// One combinational radix-2 non-restoring iteration: shift in the next dividend bit, add or
// subtract the divisor according to the sign of the partial remainder.
module nr_div_step #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH:0]   p_i,
  input  logic             q_msb_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH:0]   p_o,
  output logic             q_bit_o
);

  logic [WIDTH:0] p_sh;
  logic [WIDTH:0] b_ext;

  // |P| never exceeds B, so modular WIDTH+1 arithmetic equals the wider sum truncated.
  always_comb begin
    p_sh    = {p_i[WIDTH-1:0], q_msb_i};
    b_ext   = {1'b0, b_i};
    p_o     = p_i[WIDTH] ? (p_sh + b_ext) : (p_sh - b_ext);
    q_bit_o = ~p_o[WIDTH];
  end

endmodule

// File: rtl/nonrestoring_divider_param.sv
// Multi-cycle signed/unsigned non-restoring divider, one quotient bit per cycle.
// Define DIV_SHORTCUT_EN to finish |A| < |B| requests in a single cycle.
module nonrestoring_divider_param
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow,
  output logic             busy
);

  localparam logic [WIDTH-1:0] MinVal  = WIDTH'(div_min(WIDTH));
  localparam logic [WIDTH-1:0] OnesVal = WIDTH'(div_ones(WIDTH));

  div_state_e       state_q, state_d;
  logic [WIDTH:0]   p_q, p_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_q_q, neg_q_d;
  logic             neg_r_q, neg_r_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;

  logic             a_neg, b_neg, b_zero, is_ovf, short_hit;
  logic [WIDTH-1:0] abs_a, abs_b, r_mag;
  logic [WIDTH:0]   step_p;
  logic             step_qbit;

  nr_div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .p_i    (p_q),
    .q_msb_i(q_q[WIDTH-1]),
    .b_i    (b_q),
    .p_o    (step_p),
    .q_bit_o(step_qbit)
  );

  always_comb begin
    a_neg  = signed_mode & dividend[WIDTH-1];
    b_neg  = signed_mode & divisor[WIDTH-1];
    abs_a  = a_neg ? (~dividend + 1'b1) : dividend;
    abs_b  = b_neg ? (~divisor + 1'b1) : divisor;
    b_zero = (divisor == '0);
    is_ovf = signed_mode && (dividend == MinVal) && (divisor == OnesVal);
`ifdef DIV_SHORTCUT_EN
    short_hit = (abs_a < abs_b);
`else
    short_hit = 1'b0;
`endif
    r_mag = p_q[WIDTH] ? (p_q[WIDTH-1:0] + b_q) : p_q[WIDTH-1:0];
  end

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    b_d     = b_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          if (b_zero) begin
            quot_d  = OnesVal;
            rem_d   = dividend;
            dbz_d   = 1'b1;
            ovf_d   = 1'b0;
            state_d = StDone;
          end else if (is_ovf) begin
            quot_d  = MinVal;
            rem_d   = '0;
            dbz_d   = 1'b0;
            ovf_d   = 1'b1;
            state_d = StDone;
          end else if (short_hit) begin
            quot_d  = '0;
            rem_d   = dividend;
            dbz_d   = 1'b0;
            ovf_d   = 1'b0;
            state_d = StDone;
          end else begin
            p_d     = '0;
            b_d     = abs_b;
            q_d     = abs_a;
            cnt_d   = CNT_W'(WIDTH);
            neg_q_d = a_neg ^ b_neg;
            neg_r_d = a_neg;
            state_d = StDivide;
          end
        end
      end
      StDivide: begin
        p_d   = step_p;
        q_d   = {q_q[WIDTH-2:0], step_qbit};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = StCorrect;
      end
      StCorrect: begin
        quot_d  = neg_q_q ? (~q_q + 1'b1) : q_q;
        rem_d   = neg_r_q ? (~r_mag + 1'b1) : r_mag;
        dbz_d   = 1'b0;
        ovf_d   = 1'b0;
        state_d = StDone;
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      p_q     <= '0;
      b_q     <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      b_q     <= b_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready    = (state_q == StIdle);
  assign busy        = (state_q != StIdle);
  assign out_valid   = (state_q == StDone);
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_nonrestoring_divider_param.sv
// Directed and randomized checks of nonrestoring_divider_param at WIDTH = 8.
module tb_nonrestoring_divider_param;

  localparam int unsigned W = 8;
`ifdef DIV_SHORTCUT_EN
  localparam bit ShortEn = 1'b1;
`else
  localparam bit ShortEn = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         signed_mode = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         in_ready, out_valid, div_by_zero, overflow, busy;
  logic [W-1:0] quotient, remainder;

  int checks = 0;
  int fails = 0;

  always #5 clk = ~clk;

  nonrestoring_divider_param #(
    .WIDTH(W)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .signed_mode(signed_mode),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero),
    .overflow   (overflow),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division, C-style truncation for signed operands.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic dz, output logic ov, output int lat);
    int sa, sb;
    dz = 1'b0;
    ov = 1'b0;
    if (b == 0) begin
      q = '1; r = a; dz = 1'b1; lat = 1;
    end else if (sm && a == 8'h80 && b == 8'hFF) begin
      q = 8'h80; r = '0; ov = 1'b1; lat = 1;
    end else begin
      sa = sm ? int'($signed(a)) : int'(a);
      sb = sm ? int'($signed(b)) : int'(b);
      q = W'(sa / sb);
      r = W'(sa % sb);
      lat = W + 2;
      if (ShortEn && ((sa < 0 ? -sa : sa) < (sb < 0 ? -sb : sb))) lat = 1;
    end
  endfunction

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_before_issue", 32'(in_ready), 32'd1);
    dividend = a;
    divisor = b;
    signed_mode = sm;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Edges counted with the accept edge as edge 1.
  task automatic await_res(input string tag, input logic [W-1:0] eq, input logic [W-1:0] er,
                           input logic edz, input logic eov, input int elat);
    int edges;
    edges = 1;
    @(negedge clk);
    while (!out_valid && edges < 50) begin
      @(negedge clk);
      edges++;
    end
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_latency"}, 32'(edges), 32'(elat));
    chk({tag, "_q"}, 32'(quotient), 32'(eq));
    chk({tag, "_r"}, 32'(remainder), 32'(er));
    chk({tag, "_dbz"}, 32'(div_by_zero), 32'(edz));
    chk({tag, "_ovf"}, 32'(overflow), 32'(eov));
  endtask

  task automatic consume(input string tag, input logic [W-1:0] eq);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_consumed_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_consumed_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_q_held"}, 32'(quotient), 32'(eq));
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sm);
    logic [W-1:0] q, r;
    logic dz, ov;
    int lat;
    model(a, b, sm, q, r, dz, ov, lat);
    issue(a, b, sm);
    await_res(tag, q, r, dz, ov, lat);
    consume(tag, q);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic rs;
    int sel;

    #2 reset_n = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_q", 32'(quotient), 32'd0);
    chk("rst_r", 32'(remainder), 32'd0);
    chk("rst_flags", 32'({div_by_zero, overflow}), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Unsigned 200 / 7
    issue(8'd200, 8'd7, 1'b0);
    await_res("u200_7", 8'h1C, 8'd4, 1'b0, 1'b0, 10);
    consume("u200_7", 8'h1C);

    issue(8'hF9, 8'd2, 1'b1);
    await_res("s_m7_2", 8'hFD, 8'hFF, 1'b0, 1'b0, 10);
    consume("s_m7_2", 8'hFD);

    issue(8'd7, 8'hFE, 1'b1);
    await_res("s_7_m2", 8'hFD, 8'h01, 1'b0, 1'b0, 10);
    consume("s_7_m2", 8'hFD);

    issue(8'h5A, 8'h00, 1'b0);
    await_res("dbz", 8'hFF, 8'h5A, 1'b1, 1'b0, 1);
    consume("dbz", 8'hFF);

    issue(8'h80, 8'hFF, 1'b1);
    await_res("s_ovf", 8'h80, 8'h00, 1'b0, 1'b1, 1);
    consume("s_ovf", 8'h80);

    issue(8'h80, 8'hFF, 1'b0);
    await_res("u_128_255", 8'h00, 8'h80, 1'b0, 1'b0, ShortEn ? 1 : 10);
    consume("u_128_255", 8'h00);

    issue(8'd3, 8'd9, 1'b0);
    await_res("u_3_9", 8'h00, 8'h03, 1'b0, 1'b0, ShortEn ? 1 : 10);
    consume("u_3_9", 8'h00);

    // Backpressure: a competing request while the result is held must be dropped.
    issue(8'd200, 8'd7, 1'b0);
    await_res("bp", 8'h1C, 8'd4, 1'b0, 1'b0, 10);
    dividend = 8'd1;
    divisor = 8'd1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_ready", 32'(in_ready), 32'd0);
      chk("bp_hold_q", 32'(quotient), 32'h1C);
      chk("bp_hold_r", 32'(remainder), 32'd4);
    end
    in_valid = 1'b0;
    consume("bp", 8'h1C);
    repeat (3) @(negedge clk);
    chk("bp_not_queued_busy", 32'(busy), 32'd0);
    chk("bp_not_queued_valid", 32'(out_valid), 32'd0);
    issue(8'd50, 8'd5, 1'b0);
    await_res("bp_next", 8'd10, 8'd0, 1'b0, 1'b0, 10);
    consume("bp_next", 8'd10);

    // Reset in the fourth DIVIDE cycle.
    issue(8'd201, 8'd13, 1'b0);
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_q", 32'(quotient), 32'd0);
    chk("mid_rst_r", 32'(remainder), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("mid_rst_no_result", 32'(out_valid), 32'd0);
    issue(8'd100, 8'd10, 1'b0);
    await_res("after_rst", 8'd10, 8'd0, 1'b0, 1'b0, 10);
    consume("after_rst", 8'd10);

    for (int i = 0; i < 60; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rs = 1'($urandom);
      sel = $urandom_range(0, 9);
      if (sel == 0) rb = '0;
      if (sel == 1) begin
        ra = 8'h80;
        rb = 8'hFF;
      end
      if (sel == 2) ra = W'($urandom_range(0, 3));
      run_op("rand", ra, rb, rs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
